// File: rtl/mem_arbiter_if.sv
// Bundle between the I/D cache miss paths, the memory port and the arbiter.
// Signal names follow the cache-side and memory-side port names directly.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int LINE_WIDTH = 128
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_filled_ack;
    logic                  i_data_rdy;
    logic [LINE_WIDTH-1:0] i_data;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic                  d_filled_ack;
    logic                  d_data_rdy;
    logic [LINE_WIDTH-1:0] d_data;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [LINE_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  i_req, i_addr, i_filled_ack,
        output i_data_rdy, i_data,
        input  d_req, d_we, d_addr, d_wdata, d_filled_ack,
        output d_data_rdy, d_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr, i_filled_ack,
        input  i_data_rdy, i_data,
        output d_req, d_we, d_addr, d_wdata, d_filled_ack,
        input  d_data_rdy, d_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between the I-side and D-side cache miss paths.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default gives D-side priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_own_d;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_i_data;
    logic [LINE_WIDTH-1:0] r_d_data;
    logic                  r_i_rdy;
    logic                  r_d_rdy;

    logic w_any;
    logic w_pick_d;
    logic w_ack_own;
    logic w_idle;
    logic w_wait;
    logic w_resp;

    assign w_idle    = (r_state == IDLE);
    assign w_wait    = (r_state == WAIT);
    assign w_resp    = (r_state == RESP);
    assign w_any     = bus.i_req | bus.d_req;
    assign w_ack_own = r_own_d ? bus.d_filled_ack : bus.i_filled_ack;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last_d = 1 means D was granted last; resets to D so the first tie goes to I
    logic r_last_d;

    assign w_pick_d = bus.d_req & (~bus.i_req | ~r_last_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (w_idle && w_any) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = bus.d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any)       w_next = WAIT;
            WAIT:    if (bus.mem_ack) w_next = RESP;
            RESP:    if (w_ack_own)   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_own_d  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_i_data <= '0;
            r_d_data <= '0;
            r_i_rdy  <= 1'b0;
            r_d_rdy  <= 1'b0;
        end else begin
            if (w_idle && w_any) begin
                r_own_d <= w_pick_d;
                r_we    <= w_pick_d & bus.d_we;
                r_addr  <= w_pick_d ? bus.d_addr : bus.i_addr;
                r_wdata <= w_pick_d ? bus.d_wdata : '0;
            end
            if (w_wait && bus.mem_ack) begin
                // a write-back completion leaves the D-side line untouched
                if (!r_we) begin
                    if (r_own_d) r_d_data <= bus.mem_rdata;
                    else         r_i_data <= bus.mem_rdata;
                end
                r_d_rdy <= r_own_d;
                r_i_rdy <= ~r_own_d;
            end
            if (w_resp && w_ack_own) begin
                r_d_rdy <= 1'b0;
                r_i_rdy <= 1'b0;
            end
        end
    end

    assign bus.mem_req    = w_wait;
    assign bus.mem_we     = w_wait & r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.i_data_rdy = r_i_rdy;
    assign bus.i_data     = r_i_data;
    assign bus.d_data_rdy = r_d_rdy;
    assign bus.d_data     = r_d_data;
    assign bus.busy       = ~w_idle;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bench-side memory responder plus a queue of
// expected grants (owner, address, write data, returned line).
module tb_mem_arbiter;
    logic clk;
    logic reset;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         own_d;
        logic [19:0]  addr;
        logic         we;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } sb_t;

    sb_t sb[$];
    int n_checks = 0;
    int n_err    = 0;
    logic [127:0] m_i_data = '0;
    logic [127:0] m_d_data = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic own_d, input logic [19:0] addr,
                        input logic we, input logic [127:0] wdata,
                        input logic [127:0] rdata);
        sb_t e;
        e.own_d = own_d;
        e.addr  = addr;
        e.we    = we;
        e.wdata = wdata;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // mode 0: drop both reqs at ack; 1: owner re-raises at once; 2: one cycle later
    task automatic serve(input int lat, input int mode);
        sb_t e;
        int k;
        logic [127:0] exp_data;
        k = 0;
        while (bus.mem_req !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        chk("grant_wait", 128'(k < 30), 128'(1));
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk("mem_addr", 128'(bus.mem_addr), 128'(e.addr));
        chk("mem_we", 128'(bus.mem_we), 128'(e.we));
        if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
        repeat (lat) step();
        chk("mem_req_held", 128'(bus.mem_req), 128'(1));
        bus.mem_rdata = e.rdata;
        bus.mem_ack   = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '1;
        if (e.own_d) begin
            if (!e.we) m_d_data = e.rdata;
            exp_data = m_d_data;
        end else begin
            m_i_data = e.rdata;
            exp_data = m_i_data;
        end
        chk("mem_req_drop", 128'(bus.mem_req), 128'(0));
        chk("i_rdy_owner", 128'(bus.i_data_rdy), 128'(!e.own_d));
        chk("d_rdy_owner", 128'(bus.d_data_rdy), 128'(e.own_d));
        chk("resp_data", e.own_d ? bus.d_data : bus.i_data, exp_data);
        step();
        step();
        chk("rdy_held", 128'(e.own_d ? bus.d_data_rdy : bus.i_data_rdy), 128'(1));
        if (e.own_d) begin
            bus.d_filled_ack = 1'b1;
            bus.d_req        = 1'b0;
        end else begin
            bus.i_filled_ack = 1'b1;
            bus.i_req        = 1'b0;
        end
        if (mode == 0) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
        end
        step();
        bus.i_filled_ack = 1'b0;
        bus.d_filled_ack = 1'b0;
        chk("rdy_clear", 128'(bus.i_data_rdy | bus.d_data_rdy), 128'(0));
        chk("busy_idle", 128'(bus.busy), 128'(0));
        if (mode == 2) step();
        if (mode != 0) begin
            if (e.own_d) bus.d_req = 1'b1;
            else         bus.i_req = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("rdy_exclusive", 128'(bus.i_data_rdy & bus.d_data_rdy), 128'(0));
            chk("req_implies_busy", 128'(bus.mem_req & ~bus.busy), 128'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit   order[5];
        int   modes[5];
        logic [127:0] v;

        reset            = 1'b1;
        bus.i_req        = 1'b0;
        bus.i_addr       = '0;
        bus.i_filled_ack = 1'b0;
        bus.d_req        = 1'b0;
        bus.d_we         = 1'b0;
        bus.d_addr       = '0;
        bus.d_wdata      = '0;
        bus.d_filled_ack = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = '0;

        // reset state and grant latency
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_mem_req", 128'(bus.mem_req), 128'(0));
        chk("rst_mem_we", 128'(bus.mem_we), 128'(0));
        chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        chk("rst_mem_wdata", bus.mem_wdata, 128'(0));
        chk("rst_i_rdy", 128'(bus.i_data_rdy), 128'(0));
        chk("rst_d_rdy", 128'(bus.d_data_rdy), 128'(0));
        chk("rst_i_data", bus.i_data, 128'(0));
        chk("rst_d_data", bus.d_data, 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));

        bus.i_req  = 1'b1;
        bus.i_addr = 20'h00400;
        push(1'b0, 20'h00400, 1'b0, '0, {4{32'hDEADBEEF}});
        chk("grant_latency", 128'(bus.mem_req), 128'(0));
        step();
        chk("t1_mem_req", 128'(bus.mem_req), 128'(1));
        chk("t1_busy", 128'(bus.busy), 128'(1));
        serve(5, 0);

        // D write-back
        bus.d_we    = 1'b1;
        bus.d_addr  = 20'h00010;
        bus.d_wdata = {4{32'h11111111}};
        bus.d_req   = 1'b1;
        push(1'b1, 20'h00010, 1'b1, {4{32'h11111111}}, 128'hBAD0BAD);
        serve(3, 0);
        bus.d_we    = 1'b0;
        bus.d_wdata = '0;

        // simultaneous requests
`ifdef ARB_ROUND_ROBIN_EN
        order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        order = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        modes = '{2, 2, 1, 1, 0};
        bus.i_addr = 20'h00100;
        bus.d_addr = 20'h00200;
        for (int n = 0; n < 5; n++) begin
            v = {96'h0, 32'hA000_0000 + 32'(n)};
            push(order[n], order[n] ? 20'h00200 : 20'h00100, 1'b0, '0, v);
        end
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int n = 0; n < 5; n++) serve(2, modes[n]);
        chk("t4_sb_drained", 128'(sb.size()), 128'(0));

        // reset mid-transaction, then a late mem_ack
        bus.i_addr = 20'h00777;
        bus.i_req  = 1'b1;
        step();
        chk("t5_mem_req", 128'(bus.mem_req), 128'(1));
        reset = 1'b1;
        step();
        reset     = 1'b0;
        bus.i_req = 1'b0;
        chk("t5_rst_req", 128'(bus.mem_req), 128'(0));
        chk("t5_rst_busy", 128'(bus.busy), 128'(0));
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {4{32'hCAFEF00D}};
        step();
        bus.mem_ack = 1'b0;
        m_i_data = '0;
        m_d_data = '0;
        chk("t5_late_req", 128'(bus.mem_req), 128'(0));
        chk("t5_late_rdy", 128'(bus.i_data_rdy | bus.d_data_rdy), 128'(0));
        chk("t5_late_busy", 128'(bus.busy), 128'(0));
        chk("t5_i_data", bus.i_data, m_i_data);
        chk("t5_d_data", bus.d_data, m_d_data);

        // stray mem_ack in IDLE, foreign filled_ack in RESP
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = '1;
        step();
        bus.mem_ack = 1'b0;
        chk("t6_stray_busy", 128'(bus.busy), 128'(0));
        chk("t6_stray_i", bus.i_data, m_i_data);
        chk("t6_stray_rdy", 128'(bus.i_data_rdy | bus.d_data_rdy), 128'(0));
        bus.i_addr = 20'h0ABCD;
        bus.i_req  = 1'b1;
        step();
        chk("t6_mem_addr", 128'(bus.mem_addr), 128'(20'h0ABCD));
        bus.mem_rdata = {4{32'h5A5A1234}};
        bus.mem_ack   = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        m_i_data = {4{32'h5A5A1234}};
        chk("t6_i_rdy", 128'(bus.i_data_rdy), 128'(1));
        bus.d_filled_ack = 1'b1;
        step();
        bus.d_filled_ack = 1'b0;
        chk("t6_foreign_ack", 128'(bus.i_data_rdy), 128'(1));
        chk("t6_i_data", bus.i_data, m_i_data);
        chk("t6_busy", 128'(bus.busy), 128'(1));
        bus.i_filled_ack = 1'b1;
        bus.i_req        = 1'b0;
        step();
        bus.i_filled_ack = 1'b0;
        chk("t6_done_rdy", 128'(bus.i_data_rdy), 128'(0));
        chk("t6_done_busy", 128'(bus.busy), 128'(0));
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
